adder_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one `sync_adder` instance among `NUM_REQ` requesters. It accepts one operand pair at a time over a valid/ready handshake and drives the adder's `enable`/`a`/`b` for exactly one cycle. It then waits for the adder's `valid`, and returns the `WIDTH+1`-bit sum to the owning requester over a valid/ready response channel. The block sits between client logic and the adder; the adder's ports connect directly to the `add_*` ports below.

---
 rtl/adder_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_adder_arbiter.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_arbiter.sv
// Round-robin arbiter/sequencer sharing one sync_adder among NUM_REQ requesters.
// Define ADDER_ARB_FIXED_PRIO_EN to replace round-robin with fixed lowest-index priority.
module adder_arbiter #(
    parameter int WIDTH   = 8,
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid_i,
    output logic [NUM_REQ-1:0]       req_ready_o,
    input  logic [NUM_REQ*WIDTH-1:0] req_a_i,
    input  logic [NUM_REQ*WIDTH-1:0] req_b_i,
    output logic [NUM_REQ-1:0]       rsp_valid_o,
    input  logic [NUM_REQ-1:0]       rsp_ready_i,
    output logic [WIDTH:0]           rsp_sum_o,
    output logic                     add_enable_o,
    output logic [WIDTH-1:0]         add_a_o,
    output logic [WIDTH-1:0]         add_b_o,
    input  logic [WIDTH:0]           add_sum_i,
    input  logic                     add_valid_i,
    output logic                     busy_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_e;

    state_e               state_q, state_d;
    logic [IDX_W-1:0]     owner_q, owner_d;
    logic [WIDTH-1:0]     op_a_q, op_a_d;
    logic [WIDTH-1:0]     op_b_q, op_b_d;
    logic [WIDTH:0]       sum_q, sum_d;
    logic                 add_en_q, add_en_d;
    logic [NUM_REQ-1:0]   rsp_vld_q, rsp_vld_d;
    logic                 busy_q, busy_d;
`ifndef ADDER_ARB_FIXED_PRIO_EN
    logic [IDX_W-1:0]     ptr_q, ptr_d;
`endif

    logic                 grant_found;
    logic [IDX_W-1:0]     grant_idx;
    logic [WIDTH-1:0]     slice_a [NUM_REQ];
    logic [WIDTH-1:0]     slice_b [NUM_REQ];

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            slice_a[i] = req_a_i[i*WIDTH +: WIDTH];
            slice_b[i] = req_b_i[i*WIDTH +: WIDTH];
        end
    end

`ifdef ADDER_ARB_FIXED_PRIO_EN
    // Descending scan so the lowest asserted index is the last one written.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid_i[IDX_W'(i)]) begin
                grant_found = 1'b1;
                grant_idx   = IDX_W'(i);
            end
        end
    end
`else
    // Scan offsets from ptr downward so the smallest offset from ptr wins.
    always_comb begin
        int               pos;
        logic [IDX_W-1:0] cand;
        pos         = 0;
        cand        = '0;
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int off = NUM_REQ - 1; off >= 0; off--) begin
            pos = int'(ptr_q) + off;
            if (pos >= NUM_REQ) begin
                pos = pos - NUM_REQ;
            end
            cand = IDX_W'(pos);
            if (req_valid_i[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end
`endif

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        sum_d       = sum_q;
        add_en_d    = 1'b0;
        rsp_vld_d   = rsp_vld_q;
        req_ready_o = '0;
`ifndef ADDER_ARB_FIXED_PRIO_EN
        ptr_d       = ptr_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (grant_found) begin
                    // Gated by rst_n so req_ready reads 0 while reset is held.
                    req_ready_o[grant_idx] = rst_n;
                    owner_d  = grant_idx;
                    op_a_d   = slice_a[grant_idx];
                    op_b_d   = slice_b[grant_idx];
                    add_en_d = 1'b1;
                    state_d  = S_ISSUE;
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (add_valid_i) begin
                    sum_d     = add_sum_i;
                    rsp_vld_d = NUM_REQ'(1) << owner_q;
                    state_d   = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready_i[owner_q]) begin
                    rsp_vld_d = '0;
                    state_d   = S_IDLE;
`ifndef ADDER_ARB_FIXED_PRIO_EN
                    ptr_d     = (owner_q == IDX_W'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
`endif
                end
            end
            default: begin
                state_d   = S_IDLE;
                rsp_vld_d = '0;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            owner_q   <= '0;
            op_a_q    <= '0;
            op_b_q    <= '0;
            sum_q     <= '0;
            add_en_q  <= 1'b0;
            rsp_vld_q <= '0;
            busy_q    <= 1'b0;
`ifndef ADDER_ARB_FIXED_PRIO_EN
            ptr_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            op_a_q    <= op_a_d;
            op_b_q    <= op_b_d;
            sum_q     <= sum_d;
            add_en_q  <= add_en_d;
            rsp_vld_q <= rsp_vld_d;
            busy_q    <= busy_d;
`ifndef ADDER_ARB_FIXED_PRIO_EN
            ptr_q     <= ptr_d;
`endif
        end
    end

    // The adder sees the operand registers directly; add_enable qualifies them.
    assign add_enable_o = add_en_q;
    assign add_a_o      = op_a_q;
    assign add_b_o      = op_b_q;
    assign rsp_valid_o  = rsp_vld_q;
    assign rsp_sum_o    = sum_q;
    assign busy_o       = busy_q;

    a_req_ready_onehot: assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0(req_ready_o));
    a_rsp_valid_onehot: assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0(rsp_valid_o));
    a_rsp_sum_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (state_q == S_RESP && state_d == S_RESP) |=> $stable(rsp_sum_o));

endmodule

// File: tb/tb_adder_arbiter.sv
// Self-checking bench for adder_arbiter: vector table, directed corner sequences,
// and randomized traffic against a transaction-level reference model.
module tb_adder_arbiter;
    localparam int W = 8;
    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   req_valid = '0;
    logic [N-1:0]   req_ready;
    logic [N*W-1:0] req_a = '0;
    logic [N*W-1:0] req_b = '0;
    logic [N-1:0]   rsp_valid;
    logic [N-1:0]   rsp_ready = '0;
    logic [W:0]     rsp_sum;
    logic           add_enable;
    logic [W-1:0]   add_a;
    logic [W-1:0]   add_b;
    logic [W:0]     add_sum;
    logic           add_valid;
    logic           busy;

    int checks = 0;
    int failures = 0;

    // Behavioural stand-in for sync_adder with configurable latency.
    int         lat = 1;
    logic       stray_vld = 1'b0;
    logic       mdl_vld;
    int         cnt;
    logic [W:0] psum;
    logic [W:0] mdl_sum;

    assign add_valid = mdl_vld | stray_vld;
    assign add_sum   = mdl_sum;

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mdl_vld <= 1'b0;
            cnt     <= 0;
            psum    <= '0;
            mdl_sum <= '0;
        end else begin
            mdl_vld <= 1'b0;
            if (cnt > 0) begin
                cnt <= cnt - 1;
                if (cnt == 1) begin
                    mdl_vld <= 1'b1;
                    mdl_sum <= psum;
                end
            end
            if (add_enable) begin
                if (lat <= 1) begin
                    mdl_vld <= 1'b1;
                    mdl_sum <= {1'b0, add_a} + {1'b0, add_b};
                end else begin
                    psum <= {1'b0, add_a} + {1'b0, add_b};
                    cnt  <= lat - 1;
                end
            end
        end
    end

    adder_arbiter #(.WIDTH(W), .NUM_REQ(N)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_a_i     (req_a),
        .req_b_i     (req_b),
        .rsp_valid_o (rsp_valid),
        .rsp_ready_i (rsp_ready),
        .rsp_sum_o   (rsp_sum),
        .add_enable_o(add_enable),
        .add_a_o     (add_a),
        .add_b_o     (add_b),
        .add_sum_i   (add_sum),
        .add_valid_i (add_valid),
        .busy_o      (busy)
    );

    typedef struct {
        int         idx;
        logic [7:0] a;
        logic [7:0] b;
        logic [8:0] sum;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        req_valid = '0;
        rsp_ready = '0;
        stray_vld = 1'b0;
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_req_ready"},  32'(req_ready),  0);
        chk({tag, "_rsp_valid"},  32'(rsp_valid),  0);
        chk({tag, "_rsp_sum"},    32'(rsp_sum),    0);
        chk({tag, "_add_enable"}, 32'(add_enable), 0);
        chk({tag, "_add_a"},      32'(add_a),      0);
        chk({tag, "_add_b"},      32'(add_b),      0);
        chk({tag, "_busy"},       32'(busy),       0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_inputs();
        lat = 1;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic set_ops(input int idx, input logic [7:0] a, input logic [7:0] b);
        req_a[idx*W +: W] = a;
        req_b[idx*W +: W] = b;
    endtask

    // One isolated transaction with rsp_ready held high; starts and ends in IDLE.
    task automatic txn(input int idx, input logic [7:0] a, input logic [7:0] b,
                       input logic [8:0] exp_sum, input string tag);
        set_ops(idx, a, b);
        req_valid = N'(1) << idx;
        rsp_ready = '1;
        #1;
        chk({tag, "_c0_req_ready"}, 32'(req_ready), 32'(N'(1) << idx));
        tick();
        req_valid = '0;
        #1;
        chk({tag, "_c1_add_enable"}, 32'(add_enable), 1);
        chk({tag, "_c1_add_a"},      32'(add_a),      32'(a));
        chk({tag, "_c1_add_b"},      32'(add_b),      32'(b));
        chk({tag, "_c1_busy"},       32'(busy),       1);
        tick();
        chk({tag, "_c2_add_enable"}, 32'(add_enable), 0);
        chk({tag, "_c2_rsp_valid"},  32'(rsp_valid),  0);
        tick();
        chk({tag, "_c3_rsp_valid"},  32'(rsp_valid),  32'(N'(1) << idx));
        chk({tag, "_c3_rsp_sum"},    32'(rsp_sum),    32'(exp_sum));
        tick();
        chk({tag, "_c4_busy"},       32'(busy),       0);
        chk({tag, "_c4_rsp_valid"},  32'(rsp_valid),  0);
    endtask

    function automatic int model_winner(input logic [N-1:0] v, input int p);
        for (int off = 0; off < N; off++) begin
            int i = (p + off) % N;
            if (v[i]) return i;
        end
        return -1;
    endfunction

    vec_t vecs[6];

    initial begin
        int         m_phase;
        int         m_owner;
        int         m_ptr;
        int         w;
        int         drop;
        logic [8:0] m_sum;
        logic [7:0] m_a;
        logic [7:0] m_b;
        logic [N-1:0] exp_rdy;

        vecs[0] = '{2, 8'h12, 8'h34, 9'h046};
        vecs[1] = '{0, 8'hFF, 8'h01, 9'h100};
        vecs[2] = '{1, 8'hFF, 8'hFF, 9'h1FE};
        vecs[3] = '{3, 8'h00, 8'h00, 9'h000};
        vecs[4] = '{2, 8'h80, 8'h80, 9'h100};
        vecs[5] = '{0, 8'hAA, 8'h55, 9'h0FF};

        // Reset state, with a request pending so req_ready gating is exercised.
        clear_inputs();
        req_valid = 4'b0101;
        @(negedge clk);
        @(negedge clk);
        chk_outputs_zero("reset");
        req_valid = '0;
        rst_n = 1'b1;
        @(negedge clk);

        for (int k = 0; k < 6; k++) begin
            txn(vecs[k].idx, vecs[k].a, vecs[k].b, vecs[k].sum, $sformatf("vec%0d", k));
        end

        // Fairness: all requesters hold valid continuously.
        do_reset();
        for (int i = 0; i < N; i++) set_ops(i, 8'(i * 16 + 1), 8'(i + 2));
        req_valid = '1;
        rsp_ready = '1;
        for (int g = 0; g < 8; g++) begin
            #1;
`ifdef ADDER_ARB_FIXED_PRIO_EN
            chk($sformatf("fair_grant%0d", g), 32'(req_ready), 32'(4'b0001));
`else
            chk($sformatf("fair_grant%0d", g), 32'(req_ready), 32'(N'(1) << (g % N)));
`endif
            repeat (4) tick();
        end
        req_valid = '0;

        // Response backpressure with a competing requester and a non-owner rsp_ready.
        do_reset();
        set_ops(1, 8'h70, 8'h91);
        set_ops(3, 8'h05, 8'h06);
        req_valid = 4'b0010;
        rsp_ready = '0;
        #1;
        chk("bp_grant1", 32'(req_ready), 32'(4'b0010));
        tick();
        req_valid = 4'b1000;
        rsp_ready = 4'b1000;
        tick();
        tick();
        for (int k = 0; k < 5; k++) begin
            #1;
            chk($sformatf("bp_rsp_valid%0d", k), 32'(rsp_valid), 32'(4'b0010));
            chk($sformatf("bp_rsp_sum%0d", k),   32'(rsp_sum),   32'h101);
            chk($sformatf("bp_busy%0d", k),      32'(busy),      1);
            chk($sformatf("bp_req_ready%0d", k), 32'(req_ready), 0);
            tick();
        end
        rsp_ready = 4'b0010;
        #1;
        chk("bp_release_req_ready", 32'(req_ready), 0);
        chk("bp_release_rsp_valid", 32'(rsp_valid), 32'(4'b0010));
        tick();
        rsp_ready = '1;
        #1;
        chk("bp_next_grant", 32'(req_ready), 32'(4'b1000));
        chk("bp_next_rsp_valid", 32'(rsp_valid), 0);
        tick();
        req_valid = '0;
        tick();
        tick();
        chk("bp_second_rsp_valid", 32'(rsp_valid), 32'(4'b1000));
        chk("bp_second_rsp_sum",   32'(rsp_sum),   32'h00B);
        tick();

        // Pointer wrap after requester 3, then pointer after requester 1.
        do_reset();
        txn(3, 8'h01, 8'h02, 9'h003, "wrap_r3");
        set_ops(0, 8'h10, 8'h20);
        set_ops(3, 8'h30, 8'h40);
        req_valid = 4'b1001;
        #1;
        chk("wrap_grant0", 32'(req_ready), 32'(4'b0001));
        tick();
        req_valid = '0;
        repeat (3) tick();
        txn(1, 8'h03, 8'h04, 9'h007, "ptr_r1");
        req_valid = 4'b1001;
        #1;
`ifdef ADDER_ARB_FIXED_PRIO_EN
        chk("ptr_after_r1", 32'(req_ready), 32'(4'b0001));
`else
        chk("ptr_after_r1", 32'(req_ready), 32'(4'b1000));
`endif
        tick();
        req_valid = '0;
        repeat (3) tick();

        // Stray add_valid while IDLE.
        stray_vld = 1'b1;
        tick();
        stray_vld = 1'b0;
        chk("stray_busy", 32'(busy), 0);
        chk("stray_rsp_valid", 32'(rsp_valid), 0);
        tick();
        chk("stray_rsp_valid2", 32'(rsp_valid), 0);

        // Reset while waiting on a slow adder.
        lat = 4;
        set_ops(2, 8'h12, 8'h34);
        req_valid = 4'b0100;
        tick();
        req_valid = '0;
        tick();
        chk("rstwait_busy_before", 32'(busy), 1);
        tick();
        chk("rstwait_still_waiting", 32'(busy & ~|rsp_valid), 1);
        req_valid = 4'b0001;
        rst_n = 1'b0;
        #1;
        chk_outputs_zero("rstwait");
        req_valid = '0;
        tick();
        rst_n = 1'b1;
        lat = 1;
        for (int k = 0; k < 6; k++) begin
            tick();
            chk($sformatf("rstwait_no_rsp%0d", k), 32'(rsp_valid | N'(busy)), 0);
        end

        // Randomized traffic against a transaction-level model.
        do_reset();
        m_phase = 0;
        m_owner = 0;
        m_ptr   = 0;
        m_sum   = '0;
        m_a     = '0;
        m_b     = '0;
        drop    = -1;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            if (drop >= 0) req_valid[drop] = 1'b0;
            drop = -1;
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] && $urandom_range(0, 3) == 0) begin
                    set_ops(i, 8'($urandom), 8'($urandom));
                    req_valid[i] = 1'b1;
                end
            end
            rsp_ready = 4'($urandom);
            stray_vld = (m_phase != 2) && ($urandom_range(0, 7) == 0);
            if (m_phase == 0) lat = $urandom_range(1, 3);
            #1;
            w = (m_phase == 0) ? model_winner(req_valid, m_ptr) : -1;
            exp_rdy = (w >= 0) ? (N'(1) << w) : '0;
            chk("rnd_req_ready",  32'(req_ready),  32'(exp_rdy));
            chk("rnd_busy",       32'(busy),       32'(m_phase != 0));
            chk("rnd_add_enable", 32'(add_enable), 32'(m_phase == 1));
            chk("rnd_rsp_valid",  32'(rsp_valid),  32'((m_phase == 3) ? (N'(1) << m_owner) : '0));
            if (m_phase == 1) begin
                chk("rnd_add_a", 32'(add_a), 32'(m_a));
                chk("rnd_add_b", 32'(add_b), 32'(m_b));
            end
            if (m_phase == 3) chk("rnd_rsp_sum", 32'(rsp_sum), 32'(m_sum));
            case (m_phase)
                0: if (w >= 0) begin
                    m_owner = w;
                    m_a     = req_a[w*W +: W];
                    m_b     = req_b[w*W +: W];
                    m_sum   = {1'b0, m_a} + {1'b0, m_b};
                    drop    = w;
                    m_phase = 1;
                end
                1: m_phase = 2;
                2: if (add_valid) m_phase = 3;
                default: if (rsp_ready[m_owner]) begin
                    m_phase = 0;
`ifndef ADDER_ARB_FIXED_PRIO_EN
                    m_ptr = (m_owner + 1) % N;
`endif
                end
            endcase
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
